// File: rtl/bg_vram_arbiter_if.sv
// Bus bundle between the BG VRAM arbiter and its surroundings.
//   Display fetch: blank, disp_req, disp_addr -> disp_rvalid, disp_rdata, disp_drop (drop_clr clears)
//   CPU/loader   : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_ack, cpu_rdata
//   RAM port     : ram_en, ram_we, ram_addr, ram_din -> ram_dout
// modport slave is the arbiter; modport master is the requesters plus the RAM read port.
interface bg_vram_arbiter_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 9
);
    logic              blank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_drop;
    logic              drop_clr;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  blank, disp_req, disp_addr, drop_clr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_dout,
        output disp_rvalid, disp_rdata, disp_drop,
        output cpu_ack, cpu_rdata,
        output ram_en, ram_we, ram_addr, ram_din
    );

    modport master (
        output blank, disp_req, disp_addr, drop_clr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_dout,
        input  disp_rvalid, disp_rdata, disp_drop,
        input  cpu_ack, cpu_rdata,
        input  ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/bg_vram_arbiter.sv
// BG VRAM arbiter: shares the single BG VRAM port between the background
// fetcher (priority in active video) and the CPU/loader (priority in blanking).
// One access per cycle; reads are tagged and returned data is steered to the
// requester that issued them.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bg_vram_arbiter_if.slave (display, CPU and RAM port signals)
// Optional feature: define BG_ARB_STARVE_GUARD_EN to add a CPU starvation
// counter that forces a CPU grant after MAX_WAIT lost cycles.
module bg_vram_arbiter #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 9,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    bg_vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_ISSUE = 2'd1,
        C_RD    = 2'd2
    } cpu_state_e;

    if (RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 1) begin : g_param_chk
        $error("bg_vram_arbiter: RD_LAT must be 1..4 and MAX_WAIT at least 1");
    end

    cpu_state_e        r_state;
    cpu_state_e        w_state_nxt;
    logic              r_cpu_we;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_disp_drop;
    logic [RD_LAT:0]   r_tag_vld;
    logic [RD_LAT:0]   r_tag_cpu;

    logic              w_cpu_elig;
    logic              w_force;
    logic              w_cpu_win;
    logic              w_disp_win;
    logic              w_disp_lost;
    logic              w_rd0;
    logic              w_disp_mature;
    logic              w_cpu_mature;
    logic              w_cpu_ack;
    logic [DATA_W-1:0] w_cpu_rdata;

    // Arbitration: CPU only eligible while its FSM is idle
    assign w_cpu_elig  = bus.cpu_req && (r_state == C_IDLE);
    assign w_cpu_win   = w_cpu_elig && (!bus.disp_req || bus.blank || w_force);
    assign w_disp_win  = bus.disp_req && !w_cpu_win;
    assign w_disp_lost = bus.disp_req && w_cpu_win;
    assign w_rd0       = w_disp_win || (w_cpu_win && !bus.cpu_we);

`ifdef BG_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    assign w_force = (r_wait_cnt == CNT_W'(MAX_WAIT));

    // Counts cycles an idle-FSM CPU request loses; saturates at MAX_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_cpu_win) begin
            r_wait_cnt <= '0;
        end else if (bus.cpu_req && (r_state == C_IDLE) && !w_force) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Registered RAM port, tag pipeline and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_tag_vld   <= '0;
            r_tag_cpu   <= '0;
            r_disp_drop <= 1'b0;
        end else begin
            r_ram_en   <= w_cpu_win || w_disp_win;
            r_ram_we   <= w_cpu_win && bus.cpu_we;
            r_ram_addr <= w_cpu_win ? bus.cpu_addr : (w_disp_win ? bus.disp_addr : '0);
            r_ram_din  <= w_cpu_win ? bus.cpu_wdata : '0;
            r_tag_vld  <= {r_tag_vld[RD_LAT-1:0], w_rd0};
            r_tag_cpu  <= {r_tag_cpu[RD_LAT-1:0], w_cpu_win};
            // a new drop wins over a clear in the same cycle
            if (w_disp_lost) begin
                r_disp_drop <= 1'b1;
            end else if (bus.drop_clr) begin
                r_disp_drop <= 1'b0;
            end
        end
    end

    // Last tag stage lines up with ram_dout
    assign w_disp_mature = r_tag_vld[RD_LAT] && !r_tag_cpu[RD_LAT];
    assign w_cpu_mature  = r_tag_vld[RD_LAT] && r_tag_cpu[RD_LAT];

    // CPU FSM state register; the write flag is captured at grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= C_IDLE;
            r_cpu_we <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cpu_win) begin
                r_cpu_we <= bus.cpu_we;
            end
        end
    end

    // CPU FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:  if (w_cpu_win) w_state_nxt = C_ISSUE;
            C_ISSUE: w_state_nxt = r_cpu_we ? C_IDLE : C_RD;
            C_RD:    if (w_cpu_mature) w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // CPU FSM outputs
    always_comb begin
        w_cpu_ack   = 1'b0;
        w_cpu_rdata = '0;
        case (r_state)
            C_ISSUE: w_cpu_ack = r_cpu_we;
            C_RD: begin
                if (w_cpu_mature) begin
                    w_cpu_ack   = 1'b1;
                    w_cpu_rdata = bus.ram_dout;
                end
            end
            default: ;
        endcase
    end

    assign bus.ram_en      = r_ram_en;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_din     = r_ram_din;
    assign bus.disp_rvalid = w_disp_mature;
    assign bus.disp_rdata  = w_disp_mature ? bus.ram_dout : '0;
    assign bus.disp_drop   = r_disp_drop;
    assign bus.cpu_ack     = w_cpu_ack;
    assign bus.cpu_rdata   = w_cpu_rdata;

endmodule

// File: tb/tb_bg_vram_arbiter.sv
// Scoreboard bench for bg_vram_arbiter with a write-first RD_LAT=1 RAM model.
module tb_bg_vram_arbiter;

    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned DATA_W   = 9;
    localparam int unsigned MAX_WAIT = 4;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
        bit                is_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bg_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bg_vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_ack = 0;
    int   n_rv = 0;
    int   n_ram = 0;
    exp_t dq[$];
    exp_t cq[$];
    logic [DATA_W-1:0] mem [2**ADDR_W];

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return DATA_W'((a * 37 + 11) % 512);
    endfunction

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = init_val(i);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // write-first RAM, one cycle read latency
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_din;
                bus.ram_dout      <= bus.ram_din;
            end else begin
                bus.ram_dout <= mem[bus.ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops expected responses whenever the DUT presents one
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.ram_en) n_ram++;
        if (bus.disp_rvalid) begin
            n_rv++;
            if (dq.size() == 0) begin
                chk("disp_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = dq.pop_front();
                chk("disp_cycle", 64'(cyc), 64'(e.cyc));
                chk("disp_rdata", 64'(bus.disp_rdata), 64'(e.data));
            end
        end
        if (bus.cpu_ack) begin
            n_ack++;
            if (cq.size() == 0) begin
                chk("cpu_unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = cq.pop_front();
                chk("cpu_ack_cycle", 64'(cyc), 64'(e.cyc));
                if (e.is_rd) chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.disp_rvalid, bus.disp_rdata, bus.disp_drop, bus.cpu_ack,
                    bus.cpu_rdata, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din});
    endfunction

    task automatic push_cpu(input int c, input logic [DATA_W-1:0] d, input bit rd);
        exp_t e;
        e.cyc = c; e.data = d; e.is_rd = rd;
        cq.push_back(e);
    endtask

    task automatic push_disp(input int c, input logic [DATA_W-1:0] d);
        exp_t e;
        e.cyc = c; e.data = d; e.is_rd = 1'b1;
        dq.push_back(e);
    endtask

    // wait (bounded) for cpu_ack, then drop cpu_req right after the ack cycle
    task automatic wait_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd1);
        step();
        bus.cpu_req = 1'b0;
    endtask

    initial begin : stim
        int  k;
        int  a0;
        int  r0;
        int  ram0;
        bit  clr;
        bus.blank = 1'b0; bus.disp_req = 1'b0; bus.disp_addr = '0; bus.drop_clr = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // test 1: reset in the middle of a CPU read discards it
        step();
        bus.blank = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h123;
        step();
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        chk("midop_reset_outputs", all_outs(), 64'd0);
        a0 = n_ack; r0 = n_rv;
        step();
        chk("reset_hold_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        chk("reset_no_ack", 64'(n_ack - a0), 64'd0);
        chk("reset_no_rvalid", 64'(n_rv - r0), 64'd0);

        // test 2: display streaming during active video
        bus.blank = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            bus.disp_req = 1'b1;
            bus.disp_addr = ADDR_W'(i);
            push_disp(cyc + 2, init_val(i));
        end
        step();
        bus.disp_req = 1'b0;
        repeat (3) step();
        chk("t2_no_drop", 64'(bus.disp_drop), 64'd0);
        chk("t2_disp_drained", 64'(dq.size()), 64'd0);

        // test 3: CPU write then read during blanking
        bus.blank = 1'b1;
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h123; bus.cpu_wdata = 9'h1A5;
        push_cpu(cyc + 1, '0, 1'b0);
        wait_ack("t3_write_ack_seen");
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
        push_cpu(cyc + 2, 9'h1A5, 1'b1);
        wait_ack("t3_read_ack_seen");

        // test 4: collision during blanking, CPU wins, display drop is sticky
        step();
        k = cyc;
        bus.disp_req = 1'b1; bus.disp_addr = 11'd5;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h200; bus.cpu_wdata = 9'h055;
        push_cpu(k + 1, '0, 1'b0);
        step();
        bus.disp_req = 1'b0;
        chk("t4_ram_en", 64'(bus.ram_en), 64'd1);
        chk("t4_ram_we", 64'(bus.ram_we), 64'd1);
        chk("t4_ram_addr", 64'(bus.ram_addr), 64'h200);
        chk("t4_ram_din", 64'(bus.ram_din), 64'h055);
        chk("t4_drop_set", 64'(bus.disp_drop), 64'd1);
        step();
        bus.cpu_req = 1'b0;
        chk("t4_drop_sticky", 64'(bus.disp_drop), 64'd1);
        bus.drop_clr = 1'b1;
        step();
        bus.drop_clr = 1'b0;
        chk("t4_drop_cleared", 64'(bus.disp_drop), 64'd0);

        // test 5: CPU held during continuous display traffic in active video
        bus.blank = 1'b0;
        clr = 1'b0;
        step();
        k = cyc;
`ifdef BG_ARB_STARVE_GUARD_EN
        push_cpu(k + 6, 9'h1A5, 1'b1);
`else
        push_cpu(k + 12, 9'h1A5, 1'b1);
`endif
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            if (clr) bus.cpu_req = 1'b0;
            if (i == 0) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h123;
            end
            if (i < 10) begin
                bus.disp_req = 1'b1;
                bus.disp_addr = ADDR_W'(12'h300 + i);
`ifdef BG_ARB_STARVE_GUARD_EN
                if (i != 4) push_disp(k + i + 2, init_val(12'h300 + i));
`else
                push_disp(k + i + 2, init_val(12'h300 + i));
`endif
            end else begin
                bus.disp_req = 1'b0;
            end
            @(negedge clk);
            if (bus.cpu_ack) clr = 1'b1;
        end
        step();
        bus.cpu_req = 1'b0;
`ifdef BG_ARB_STARVE_GUARD_EN
        chk("t5_guard_drop", 64'(bus.disp_drop), 64'd1);
`else
        chk("t5_no_drop", 64'(bus.disp_drop), 64'd0);
`endif
        chk("t5_cpu_drained", 64'(cq.size()), 64'd0);
        bus.drop_clr = 1'b1;
        step();
        bus.drop_clr = 1'b0;

        // test 6: cpu_req held across a read ack -> single access, single ack
        bus.blank = 1'b1;
        step();
        a0 = n_ack; ram0 = n_ram;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h200;
        push_cpu(cyc + 2, 9'h055, 1'b1);
        wait_ack("t6_ack_seen");
        repeat (3) step();
        chk("t6_one_ram_access", 64'(n_ram - ram0), 64'd1);
        chk("t6_one_ack", 64'(n_ack - a0), 64'd1);

        repeat (3) step();
        chk("final_disp_queue_empty", 64'(dq.size()), 64'd0);
        chk("final_cpu_queue_empty", 64'(cq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
